// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: sequential instruction prefetcher with a DEPTH-entry queue toward decode.
// Optional macro FETCH_QUEUE_BYPASS_EN: an ack into an empty queue is forwarded to decode in the same cycle.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_ack,
  input  logic [31:0]            imem_rdata,
  output logic                   inst_valid,
  input  logic                   inst_ready,
  output logic [31:0]            inst_data,
  output logic [31:0]            inst_pc,
  output logic [31:0]            inst_next_pc,
  output logic [$clog2(DEPTH):0] count,
  output logic [1:0]             fsm_state
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    KILL = 2'd2
  } state_t;

  // Handshakes: imem_req/imem_addr hold until imem_ack (ack may come in the first
  // request cycle); a decode transfer happens on any edge where inst_valid && inst_ready.

  state_t          state_q, state_d;
  logic            req_q, req_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;

  logic [31:0]     q_data [DEPTH];
  logic [31:0]     q_pc   [DEPTH];
  logic [31:0]     q_next [DEPTH];

  logic            head_valid;
  logic            ack_take;
  logic            bypass;
  logic            pop;
  logic            push;

  assign head_valid = (count_q != '0);
  assign ack_take   = (state_q == WAIT) && imem_ack;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = !head_valid && ack_take && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign pop  = head_valid && inst_ready;
  // A bypassed response taken by decode never enters the queue.
  assign push = ack_take && !redirect_valid && !(bypass && inst_ready);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (count_q < FULL) begin
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = KILL;
          end
        end else if (imem_ack) begin
          fetch_pc_d = fetch_pc_q + 32'd4;
          if (count_d < FULL) begin
            addr_d = fetch_pc_q + 32'd4;
          end else begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      KILL: begin
        // The stale request must still complete; its data is dropped.
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      addr_q     <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_data[i] <= '0;
        q_pc[i]   <= '0;
        q_next[i] <= '0;
      end
    end else if (push) begin
      q_data[wr_ptr_q] <= imem_rdata;
      q_pc[wr_ptr_q]   <= addr_q;
      q_next[wr_ptr_q] <= addr_q + 32'd4;
    end
  end

  always_comb begin
    inst_valid   = head_valid;
    inst_data    = q_data[rd_ptr_q];
    inst_pc      = q_pc[rd_ptr_q];
    inst_next_pc = q_next[rd_ptr_q];
`ifdef FETCH_QUEUE_BYPASS_EN
    if (bypass) begin
      inst_valid   = 1'b1;
      inst_data    = imem_rdata;
      inst_pc      = addr_q;
      inst_next_pc = addr_q + 32'd4;
    end
`endif
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign count     = count_q;
  assign fsm_state = state_q;

endmodule
